// File: rtl/note_sequencer_pkg.sv
// Shared types for the note sequencer: FSM states, note-table entry layout and the end-of-melody marker.
// Entry field widths are fixed here so they line up with the sin_gen increment and the duration field.
package note_seq_pkg;

    localparam int INCR_W = 16;
    localparam int DUR_W  = 8;

    // A duration of zero terminates the melody.
    localparam logic [DUR_W-1:0] END_MARKER_DUR = '0;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHECK,
        PLAY,
        GAP,
        ADV,
        DONE
    } seq_state_e;

    typedef struct packed {
        logic [INCR_W-1:0] incr;
        logic [DUR_W-1:0]  dur;
        logic [1:0]        vol;
    } note_entry_t;

endpackage

// File: rtl/note_sequencer_if.sv
// Control, table-load and tone-output bundle between the board controls and the note sequencer.
// state is a debug view of the sequencer FSM.
interface note_sequencer_if #(
    parameter int NOTES = 16
);
    import note_seq_pkg::*;

    localparam int IDX_W = $clog2(NOTES);

    logic              sample_tick;
    logic              start;
    logic              stop;
    logic              loop;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_addr;
    logic [INCR_W-1:0] wr_incr;
    logic [DUR_W-1:0]  wr_dur;
    logic [1:0]        wr_vol;

    logic [INCR_W-1:0] increment;
    logic [1:0]        volume;
    logic              mute;
    logic              busy;
    logic [IDX_W-1:0]  note_idx;
    logic              done;
    seq_state_e        state;

    modport master (
        output sample_tick, start, stop, loop, wr_en, wr_addr, wr_incr, wr_dur, wr_vol,
        input  increment, volume, mute, busy, note_idx, done, state
    );

    modport slave (
        input  sample_tick, start, stop, loop, wr_en, wr_addr, wr_incr, wr_dur, wr_vol,
        output increment, volume, mute, busy, note_idx, done, state
    );

endinterface

// File: rtl/note_sequencer_table.sv
// note_table: NOTES-deep single-write/single-read note RAM with a registered read port.
// Contents are deliberately not reset; the melody is loaded by the controls.
module note_table
    import note_seq_pkg::*;
#(
    parameter int NOTES = 16,
    parameter int AW    = $clog2(NOTES)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  note_entry_t   wr_data,
    input  logic [AW-1:0] rd_addr,
    output note_entry_t   rd_data
);

    note_entry_t mem_q [NOTES];
    note_entry_t rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: plays the stored melody, timing notes in audio sample ticks and driving sin_gen/audio_gen.
// Optional macro SEQ_GAP_EN inserts a muted GAP of GAP_SAMPLES ticks after each note (legato otherwise).
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int NOTES        = 16,
    parameter int TICK_SAMPLES = 480,
    parameter int GAP_SAMPLES  = 96
) (
    input logic             clk,
    input logic             reset_n,
    note_sequencer_if.slave seq
);

    localparam int IDX_W  = $clog2(NOTES);
    localparam int SAMP_W = (TICK_SAMPLES > 1) ? $clog2(TICK_SAMPLES) : 1;
    localparam int GAP_W  = (GAP_SAMPLES > 1) ? $clog2(GAP_SAMPLES) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NOTES - 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(TICK_SAMPLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_SAMPLES - 1);

    seq_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SAMP_W-1:0] samp_q, samp_d;
    logic [DUR_W-1:0]  unit_q, unit_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [INCR_W-1:0] incr_q, incr_d;
    logic [1:0]        vol_q, vol_d;
    logic              mute_q, mute_d;
    logic              sample_tick_q;
    logic              tick;
    note_entry_t       wr_entry;
    note_entry_t       rd_entry;

    // data_ready is a level; only its rising edge is one audio sample.
    assign tick     = seq.sample_tick & ~sample_tick_q;
    assign wr_entry = '{incr: seq.wr_incr, dur: seq.wr_dur, vol: seq.wr_vol};

    note_table #(
        .NOTES (NOTES),
        .AW    (IDX_W)
    ) u_table (
        .clk     (clk),
        .wr_en   (seq.wr_en),
        .wr_addr (seq.wr_addr),
        .wr_data (wr_entry),
        .rd_addr (idx_q),
        .rd_data (rd_entry)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            samp_q        <= '0;
            unit_q        <= '0;
            gap_q         <= '0;
            dur_q         <= '0;
            incr_q        <= '0;
            vol_q         <= '0;
            mute_q        <= 1'b1;
            sample_tick_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            samp_q        <= samp_d;
            unit_q        <= unit_d;
            gap_q         <= gap_d;
            dur_q         <= dur_d;
            incr_q        <= incr_d;
            vol_q         <= vol_d;
            mute_q        <= mute_d;
            sample_tick_q <= seq.sample_tick;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        samp_d  = samp_q;
        unit_d  = unit_q;
        gap_d   = gap_q;
        dur_d   = dur_q;
        incr_d  = incr_q;
        vol_d   = vol_q;
        mute_d  = mute_q;
        case (state_q)
            IDLE: begin
                mute_d = 1'b1;
                if (seq.start) begin
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: state_d = CHECK;
            CHECK: begin
                // An end marker at entry 0 is an empty melody; never loop on it.
                if (rd_entry.dur == END_MARKER_DUR) begin
                    if (idx_q == '0 || !seq.loop) begin
                        mute_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        idx_d   = '0;
                        state_d = LOAD;
                    end
                end else begin
                    incr_d  = rd_entry.incr;
                    vol_d   = rd_entry.vol;
                    dur_d   = rd_entry.dur;
                    mute_d  = 1'b0;
                    state_d = PLAY;
                end
            end
            PLAY: begin
                if (tick) begin
                    if (samp_q == SAMP_LAST) begin
                        samp_d = '0;
                        if (unit_q + DUR_W'(1) == dur_q) begin
                            unit_d = '0;
`ifdef SEQ_GAP_EN
                            mute_d  = 1'b1;
                            state_d = GAP;
`else
                            state_d = ADV;
`endif
                        end else begin
                            unit_d = unit_q + DUR_W'(1);
                        end
                    end else begin
                        samp_d = samp_q + SAMP_W'(1);
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (gap_q == GAP_LAST) begin
                        gap_d   = '0;
                        state_d = ADV;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
            end
            ADV: begin
                if (idx_q == IDX_LAST) begin
                    if (seq.loop) begin
                        idx_d   = '0;
                        state_d = LOAD;
                    end else begin
                        mute_d  = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = LOAD;
                end
            end
            DONE: begin
                mute_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                mute_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
        // stop overrides everything above, including a pending done.
        if (seq.stop) begin
            state_d = IDLE;
            mute_d  = 1'b1;
            idx_d   = '0;
            samp_d  = '0;
            unit_d  = '0;
            gap_d   = '0;
        end
    end

    assign seq.increment = incr_q;
    assign seq.volume    = vol_q;
    assign seq.mute      = mute_q;
    assign seq.busy      = (state_q != IDLE);
    assign seq.note_idx  = idx_q;
    assign seq.done      = (state_q == DONE);
    assign seq.state     = state_q;

endmodule
